// File: rtl/rdma_tx_framer_pkg.sv
// rtl/rdma_tx_framer_pkg.sv - shared widths, header offsets and state codes for the RDMA tx framer
package rdma_tx_framer_pkg;

  localparam int DATA_W  = 256;
  localparam int PSN_W   = 24;
  localparam int QP_W    = 24;
  localparam int FLUSH_W = 8;
  localparam int OPC_W   = 8;
  localparam int MAXB_W  = 4;

  localparam int OPC_LSB = 0;
  localparam int PSN_LSB = 8;
  localparam int QP_LSB  = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HDR  = 2'd1;
  localparam logic [1:0] ST_PAY  = 2'd2;

endpackage

// File: rtl/rdma_tx_framer_hdr_build.sv
// rtl/rdma_tx_framer_hdr_build.sv - combinational packing of the RDMA header beat
module rdma_hdr_build
  import rdma_tx_framer_pkg::*;
(
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [PSN_W-1:0]  i_psn,
  input  logic [QP_W-1:0]   i_qp,
  output logic [DATA_W-1:0] o_hdr
);

  always_comb begin
    o_hdr = '0;
    o_hdr[OPC_LSB +: OPC_W] = i_opcode;
    o_hdr[PSN_LSB +: PSN_W] = i_psn;
    o_hdr[QP_LSB  +: QP_W]  = i_qp;
  end

endmodule

// File: rtl/rdma_tx_framer.sv
// rtl/rdma_tx_framer.sv - frames send-buffer words into header+payload RDMA packets
module rdma_tx_framer
  import rdma_tx_framer_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic [DATA_W-1:0]   bufData,
  input  logic                bufReady,
  output logic                bufPop,
  input  logic                cfgEnable,
  input  logic [OPC_W-1:0]    cfgOpcode,
  input  logic [QP_W-1:0]     cfgDestQp,
  input  logic [MAXB_W-1:0]   cfgMaxBeats,
  input  logic [FLUSH_W-1:0]  cfgFlushCycles,
  output logic [DATA_W-1:0]   txData,
  output logic                txValid,
  output logic                txSop,
  output logic                txEop,
  input  logic                txReady,
  output logic                busy,
  output logic [PSN_W-1:0]    psn,
  output logic [31:0]         pktCount
);

  logic [1:0]         r_state;
  logic [DATA_W-1:0]  r_hold;
  logic [PSN_W-1:0]   r_psn;
  logic [31:0]        r_pkt_cnt;
  logic [MAXB_W-1:0]  r_beat_cnt;
  logic [FLUSH_W-1:0] r_flush_cnt;
  logic               r_eop_lock;
  logic [OPC_W-1:0]   r_opcode;
  logic [QP_W-1:0]    r_qp;

  logic [MAXB_W-1:0]  w_max;
  logic [FLUSH_W:0]   w_flush_next;
  logic               w_flush_hit;
  logic               w_eop_case;
  logic               w_accept;
  logic               w_start;
  logic [DATA_W-1:0]  w_hdr;

  rdma_hdr_build u_hdr (
    .i_opcode (r_opcode),
    .i_psn    (r_psn),
    .i_qp     (r_qp),
    .o_hdr    (w_hdr)
  );

  // >= rather than == so that lowering either limit mid-packet still closes it.
  assign w_max        = (cfgMaxBeats == '0) ? MAXB_W'(1) : cfgMaxBeats;
  assign w_eop_case   = r_eop_lock || (r_beat_cnt >= w_max);
  assign w_flush_next = {1'b0, r_flush_cnt} + (FLUSH_W+1)'(1);
  assign w_flush_hit  = w_flush_next >= {1'b0, cfgFlushCycles};
  assign w_start      = cfgEnable && bufReady;

  assign txSop    = (r_state == ST_HDR);
  assign txEop    = (r_state == ST_PAY) && w_eop_case;
  assign txValid  = txSop || ((r_state == ST_PAY) && (w_eop_case || bufReady));
  assign txData   = txSop ? w_hdr : ((r_state == ST_PAY) ? r_hold : '0);
  assign w_accept = txValid && txReady;
  assign bufPop   = w_accept && bufReady && !txEop;
  assign busy     = (r_state != ST_IDLE);
  assign psn      = r_psn;
  assign pktCount = r_pkt_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_hold      <= '0;
      r_psn       <= '0;
      r_pkt_cnt   <= '0;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_eop_lock  <= 1'b0;
      r_opcode    <= '0;
      r_qp        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_state  <= ST_HDR;
            r_opcode <= cfgOpcode;
            r_qp     <= cfgDestQp;
          end
        end
        ST_HDR: begin
          if (bufPop) begin
            r_hold      <= bufData;
            r_beat_cnt  <= MAXB_W'(1);
            r_flush_cnt <= '0;
            r_state     <= ST_PAY;
          end
        end
        ST_PAY: begin
          if (w_eop_case) begin
            if (w_accept) begin
              r_psn      <= r_psn + PSN_W'(1);
              r_pkt_cnt  <= r_pkt_cnt + 32'd1;
              r_eop_lock <= 1'b0;
              // Chain straight into the next header so back-to-back packets leave no bubble.
              if (w_start) begin
                r_state  <= ST_HDR;
                r_opcode <= cfgOpcode;
                r_qp     <= cfgDestQp;
              end else begin
                r_state <= ST_IDLE;
              end
            end
          end else if (bufReady) begin
            if (bufPop) begin
              r_hold      <= bufData;
              r_beat_cnt  <= r_beat_cnt + MAXB_W'(1);
              r_flush_cnt <= '0;
            end
          end else begin
            r_flush_cnt <= w_flush_next[FLUSH_W-1:0];
            if (w_flush_hit) r_eop_lock <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
